// File: rtl/control_sequencer_if.sv
// Bus between the instruction register / flag logic and the control sequencer.
// The sequencer sits on the slave side: it consumes opcode and flags and
// publishes the control word, the current T-state and the halt status.
interface control_sequencer_if;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    modport master (
        output opcode, flag_c, flag_z,
        input  ctrl, step, halted
    );

    modport slave (
        input  opcode, flag_c, flag_z,
        output ctrl, step, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 4-bit-address bus CPU.
// Steps a T-state counter, decodes opcode and flags, and drives the
// 16-bit control word combinationally from the current state.
module control_sequencer #(
    parameter int unsigned STEPS     = 5,
    parameter bit          EARLY_END = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.slave  bus
);

    // T-state encodings
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [2:0] LAST = 3'(STEPS - 1);

    // Control word bits
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    logic [2:0] step_nxt;

    // Microcode ROM: control word for a given T-state, opcode and flags.
    // Steps at or beyond STEPS are never issued and read as zero.
    function automatic logic [15:0] uword(
        input logic [2:0] s,
        input logic [3:0] op,
        input logic       fc,
        input logic       fz
    );
        logic [15:0] w;
        w = '0;
        if (32'(s) < STEPS) begin
            case (s)
                T0: w = CO | MI;
                T1: w = RO | II | CE;
                T2: begin
                    case (op)
                        4'b0001, 4'b0010,
                        4'b0011, 4'b0100: w = IO | MI;
                        4'b0101:          w = IO | AI;
                        4'b0110:          w = IO | J;
                        4'b0111:          w = fc ? (IO | J) : '0;
                        4'b1000:          w = fz ? (IO | J) : '0;
                        4'b1110:          w = AO | OI;
                        4'b1111:          w = HLT;
                        default:          w = '0;
                    endcase
                end
                T3: begin
                    case (op)
                        4'b0001:          w = RO | AI;
                        4'b0010, 4'b0011: w = RO | BI;
                        4'b0100:          w = AO | RI;
                        default:          w = '0;
                    endcase
                end
                T4: begin
                    case (op)
                        4'b0010: w = EO | AI | FI;
                        4'b0011: w = EO | AI | SU | FI;
                        default: w = '0;
                    endcase
                end
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    assign step_nxt = step_q + 3'd1;

    // Next-state: advance/wrap the T-state counter, optional early return, halt capture
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (step_q == LAST) begin
                step_d = T0;
            end else if (EARLY_END && (step_q >= T2) &&
                         (uword(step_nxt, bus.opcode, bus.flag_c, bus.flag_z) == '0)) begin
                step_d = T0;
            end else begin
                step_d = step_nxt;
            end
            if ((step_q == T2) && (bus.opcode == 4'b1111)) begin
                halted_d = 1'b1;
            end
        end
    end

    // State registers with synchronous clear taking priority over everything
    always_ff @(posedge clk) begin
        if (clr) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Output decode: while halted only the hlt line is asserted
    always_comb begin
        bus.ctrl   = halted_q ? HLT : uword(step_q, bus.opcode, bus.flag_c, bus.flag_z);
        bus.step   = step_q;
        bus.halted = halted_q;
    end

endmodule
